// File: rtl/crossbar_input_voq_fifo_if.sv
// Interface bundle for one crossbar input queue: the write side, arbiter request/grant,
// the registered output stage, and the status/error signals.
interface crossbar_input_voq_fifo_if #(
    parameter int WIDTH     = 320,
    parameter int DEPTH     = 64,
    parameter int NUM_PORTS = 4,
    parameter int SEL_W     = 2,
    parameter int CNT_W     = 16
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0]     in_data;
    logic [SEL_W-1:0]     in_dest;
    logic                 in_valid;
    logic                 in_ready;
    logic [NUM_PORTS-1:0] req;
    logic [NUM_PORTS-1:0] grant;
    logic [WIDTH-1:0]     out_data;
    logic [NUM_PORTS-1:0] out_valid;
    logic [CW-1:0]        count;
    logic                 full;
    logic                 empty;
    logic [CNT_W-1:0]     drop_cnt;
    logic                 grant_err;

    modport master (
        output in_data, in_dest, in_valid, grant,
        input  in_ready, req, out_data, out_valid, count, full, empty, drop_cnt, grant_err
    );

    modport slave (
        input  in_data, in_dest, in_valid, grant,
        output in_ready, req, out_data, out_valid, count, full, empty, drop_cnt, grant_err
    );
endinterface

// File: rtl/crossbar_input_voq_fifo.sv
// Crossbar input queue: circular FIFO of {dest, payload} entries, one-hot head-of-line
// request, grant-driven dequeue into a registered output stage with per-output valid.
module crossbar_input_voq_fifo #(
    parameter int WIDTH     = 320,
    parameter int DEPTH     = 64,
    parameter int NUM_PORTS = 4,
    parameter int SEL_W     = 2,
    parameter int CNT_W     = 16
) (
    input logic clk,
    input logic rst,
    crossbar_input_voq_fifo_if.slave link
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = SEL_W + WIDTH;

    logic [EW-1:0]        mem [DEPTH];
    logic [AW-1:0]        wr_ptr;
    logic [AW-1:0]        rd_ptr;
    logic [CW-1:0]        level;
    logic [CNT_W-1:0]     drops;

    logic [WIDTH-1:0]     data_p1;
    logic [NUM_PORTS-1:0] vld_p1;
    logic                 gerr_p1;

    logic [EW-1:0]        head;
    logic [SEL_W-1:0]     head_dest;
    logic [NUM_PORTS-1:0] head_req;
    logic                 is_full;
    logic                 is_empty;
    logic                 dest_ok;
    logic                 push;
    logic                 drop;
    logic                 pop;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    function automatic logic [NUM_PORTS-1:0] onehot(input logic [SEL_W-1:0] sel);
        return NUM_PORTS'(1) << sel;
    endfunction

    assign is_full   = (level == CW'(DEPTH));
    assign is_empty  = (level == '0);
    assign head      = mem[rd_ptr];
    assign head_dest = head[EW-1:WIDTH];
    assign head_req  = is_empty ? '0 : onehot(head_dest);

    // Out-of-range tags are dropped at the door, so head_dest always names a real output.
    assign dest_ok = (int'(link.in_dest) < NUM_PORTS);
    assign push    = link.in_valid && !is_full && dest_ok;
    assign drop    = link.in_valid && !push;
    assign pop     = |(link.grant & head_req);

    // Stage p0 -> p1: pointer/level update and registered dequeue output
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level   <= '0;
            drops   <= '0;
            data_p1 <= '0;
            vld_p1  <= '0;
            gerr_p1 <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   level <= level + CW'(1);
                2'b01:   level <= level - CW'(1);
                default: level <= level;
            endcase
            if (drop) drops <= sat_inc(drops);
            vld_p1 <= pop ? head_req : '0;
            if (pop) data_p1 <= head[WIDTH-1:0];
            gerr_p1 <= |(link.grant & ~head_req);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {link.in_dest, link.in_data};
    end

    assign link.in_ready  = !is_full;
    assign link.req       = head_req;
    assign link.out_data  = data_p1;
    assign link.out_valid = vld_p1;
    assign link.count     = level;
    assign link.full      = is_full;
    assign link.empty     = is_empty;
    assign link.drop_cnt  = drops;
    assign link.grant_err = gerr_p1;
endmodule

// File: tb/tb_crossbar_input_voq_fifo.sv
// Directed bench with a FIFO model and output scoreboard for the crossbar input queue.
module tb_crossbar_input_voq_fifo;
    typedef struct packed {
        logic [1:0]   dest;
        logic [319:0] data;
    } pkt_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   nchk = 0;
    int   nfail = 0;

    pkt_t         fifo_q[$];
    pkt_t         sb[$];
    logic [15:0]  mdrop = '0;
    logic [319:0] mdata = '0;

    always #5 clk = ~clk;

    crossbar_input_voq_fifo_if #(.WIDTH(320), .DEPTH(64), .NUM_PORTS(4), .SEL_W(2), .CNT_W(16)) a ();
    crossbar_input_voq_fifo_if #(.WIDTH(8), .DEPTH(4), .NUM_PORTS(3), .SEL_W(2), .CNT_W(4)) b ();

    crossbar_input_voq_fifo #(.WIDTH(320), .DEPTH(64), .NUM_PORTS(4), .SEL_W(2), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .link(a)
    );
    crossbar_input_voq_fifo #(.WIDTH(8), .DEPTH(4), .NUM_PORTS(3), .SEL_W(2), .CNT_W(4)) dut6 (
        .clk(clk), .rst(rst), .link(b)
    );

    task automatic chk(input string tag, input logic [319:0] obs, input logic [319:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock of the main queue: predict from driven inputs, step, compare.
    task automatic cycle();
        logic [3:0] mreq;
        logic       do_push, do_pop, gerr, vin;
        pkt_t       p;
        mreq = (fifo_q.size() != 0) ? (4'b0001 << fifo_q[0].dest) : 4'b0000;
        chk("req", 320'(a.req), 320'(mreq));
        chk("in_ready", 320'(a.in_ready), 320'(fifo_q.size() < 64));
        vin     = a.in_valid;
        do_push = vin && (fifo_q.size() < 64);
        do_pop  = |(a.grant & mreq);
        gerr    = |(a.grant & ~mreq);
        p.dest  = a.in_dest;
        p.data  = a.in_data;
        @(posedge clk);
        if (do_pop) sb.push_back(fifo_q.pop_front());
        if (do_push) fifo_q.push_back(p);
        if (vin && !do_push && mdrop != 16'hFFFF) mdrop = mdrop + 16'd1;
        #1;
        if (a.out_valid != 4'b0000 && sb.size() != 0) begin
            p = sb.pop_front();
            mdata = p.data;
            chk("out_valid", 320'(a.out_valid), 320'(4'b0001 << p.dest));
        end else begin
            chk("out_valid", 320'(a.out_valid), 320'(do_pop ? (4'b0001 << sb[0].dest) : 4'b0000));
            if (sb.size() != 0) void'(sb.pop_front());
        end
        chk("out_data", a.out_data, mdata);
        chk("count", 320'(a.count), 320'(fifo_q.size()));
        chk("empty", 320'(a.empty), 320'(fifo_q.size() == 0));
        chk("full", 320'(a.full), 320'(fifo_q.size() == 64));
        chk("drop_cnt", 320'(a.drop_cnt), 320'(mdrop));
        chk("grant_err", 320'(a.grant_err), 320'(gerr));
    endtask

    task automatic grant_head();
        a.grant = (fifo_q.size() != 0) ? (4'b0001 << fifo_q[0].dest) : 4'b0000;
    endtask

    initial begin
        a.in_data = '0; a.in_dest = '0; a.in_valid = 1'b0; a.grant = '0;
        b.in_data = '0; b.in_dest = '0; b.in_valid = 1'b0; b.grant = '0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_count", 320'(a.count), 320'(0));
        chk("rst_empty", 320'(a.empty), 320'(1));
        chk("rst_req", 320'(a.req), 320'(0));
        chk("rst_out_valid", 320'(a.out_valid), 320'(0));
        chk("rst_out_data", a.out_data, 320'(0));
        chk("rst_drop_cnt", 320'(a.drop_cnt), 320'(0));
        chk("rst_grant_err", 320'(a.grant_err), 320'(0));
        rst = 1'b1;

        // Single packet to output 2
        a.in_valid = 1'b1; a.in_dest = 2'd2; a.in_data = 320'hA5;
        cycle();
        a.in_valid = 1'b0;
        cycle();
        a.grant = 4'b0100;
        cycle();
        chk("t2_out_data", a.out_data, 320'hA5);
        a.grant = 4'b0000;
        cycle();

        // Fill to full, overflow, refused push under pop, then back-to-back drain
        for (int i = 0; i < 64; i++) begin
            a.in_valid = 1'b1; a.in_dest = 2'(i % 4);
            a.in_data = {10{32'(i) ^ 32'hDEAD0000}};
            cycle();
        end
        chk("t3_full", 320'(a.full), 320'(1));
        for (int i = 0; i < 3; i++) begin
            a.in_data = 320'(i + 1000);
            cycle();
        end
        chk("t3_drop3", 320'(a.drop_cnt), 320'(3));
        grant_head();
        cycle();
        a.in_valid = 1'b0;
        for (int i = 0; i < 64 && fifo_q.size() != 0; i++) begin
            grant_head();
            cycle();
        end
        a.grant = 4'b0000;
        cycle();

        // Steady level 10 with simultaneous push and matching grant
        for (int i = 0; i < 10; i++) begin
            a.in_valid = 1'b1; a.in_dest = 2'((i * 3) % 4); a.in_data = 320'(i) << 200;
            cycle();
        end
        for (int i = 0; i < 5; i++) begin
            a.in_dest = 2'(i % 4); a.in_data = 320'(i + 77);
            grant_head();
            cycle();
        end
        chk("t4_level", 320'(a.count), 320'(10));
        a.in_valid = 1'b0;
        for (int i = 0; i < 20 && fifo_q.size() != 0; i++) begin
            grant_head();
            cycle();
        end
        a.grant = 4'b0000;

        // Push and grant together on an empty queue, then a stray grant at the head
        a.in_valid = 1'b1; a.in_dest = 2'd1; a.in_data = 320'h1234;
        a.grant = 4'b0010;
        cycle();
        a.in_valid = 1'b0; a.grant = 4'b1000;
        cycle();
        chk("t5_gerr", 320'(a.grant_err), 320'(1));
        a.grant = 4'b0000;
        cycle();
        a.grant = 4'b0010;
        cycle();
        chk("t5_pop_data", a.out_data, 320'h1234);
        a.grant = 4'b0000;
        cycle();

        // Narrow instance: out-of-range tag drops and drop counter saturation
        for (int i = 0; i < 20; i++) begin
            b.in_valid = 1'b1; b.in_dest = 2'd3; b.in_data = 8'(i);
            @(posedge clk);
            #1;
            chk("t6_drop_cnt", 320'(b.drop_cnt), 320'((i + 1 > 15) ? 15 : i + 1));
            chk("t6_count", 320'(b.count), 320'(0));
        end
        b.in_valid = 1'b0;
        chk("t6_req", 320'(b.req), 320'(0));

        // Asynchronous reset in the middle of traffic
        for (int i = 0; i < 3; i++) begin
            a.in_valid = 1'b1; a.in_dest = 2'(i); a.in_data = 320'(i + 500);
            cycle();
        end
        a.in_valid = 1'b0;
        a.in_valid = 1'b1; a.in_dest = 2'd0; a.in_data = 320'h3;
        cycle();
        a.in_valid = 1'b1; a.in_dest = 2'd3; a.in_data = 320'h4;
        grant_head();
        cycle();
        a.in_valid = 1'b0; a.grant = 4'b0000;
        #2;
        rst = 1'b0;
        #1;
        chk("arst_count", 320'(a.count), 320'(0));
        chk("arst_empty", 320'(a.empty), 320'(1));
        chk("arst_req", 320'(a.req), 320'(0));
        chk("arst_out_valid", 320'(a.out_valid), 320'(0));
        chk("arst_drop_cnt", 320'(a.drop_cnt), 320'(0));
        chk("arst_drop_cnt_b", 320'(b.drop_cnt), 320'(0));
        chk("arst_grant_err", 320'(a.grant_err), 320'(0));
        fifo_q.delete(); sb.delete(); mdrop = '0; mdata = '0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end
endmodule
